// File: rtl/parking_lane_ctrl_if.sv
// Sensor inputs and occupancy/event outputs of the parking lane controller.
interface parking_lane_ctrl_if #(parameter int CNT_W = 3);
  logic             sens_a_i;
  logic             sens_b_i;
  logic [CNT_W-1:0] occ_o;
  logic             full_o;
  logic             empty_o;
  logic             enter_p_o;
  logic             exit_p_o;
  logic             err_p_o;
  logic [3:0]       led_o;

  modport slave  (input  sens_a_i, sens_b_i,
                  output occ_o, full_o, empty_o, enter_p_o, exit_p_o, err_p_o, led_o);
  modport master (output sens_a_i, sens_b_i,
                  input  occ_o, full_o, empty_o, enter_p_o, exit_p_o, err_p_o, led_o);
endinterface

// File: rtl/parking_lane_ctrl.sv
// Bidirectional parking lane controller: sync + debounce of two sensors,
// A/B sequence FSM and saturating occupancy counter with event pulses.
module parking_lane_ctrl #(
  parameter int CAPACITY       = 7,
  parameter int CNT_W          = 3,
  parameter int DEB_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic             clk,
  input logic             rst_n,
  parking_lane_ctrl_if.slave bus
);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, ERRW} st_t;

  // bit 1 = a (street side), bit 0 = b (lot side)
  logic [1:0]          raw;
  logic [1:0]          s1_q, s2_q, filt_q;
  logic [1:0][DW-1:0]  dcnt_q;

  assign raw = {bus.sens_a_i, bus.sens_b_i};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      filt_q <= '0;
      dcnt_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          dcnt_q[i] <= '0;
        end else if (dcnt_q[i] == DW'(DEB_CYCLES - 1)) begin
          filt_q[i] <= s2_q[i];
          dcnt_q[i] <= '0;
        end else begin
          dcnt_q[i] <= dcnt_q[i] + 1'b1;
        end
      end
    end
  end

  st_t              state_q, state_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             full_q, empty_q, enter_q, exit_q, err_q;
  logic             enter_d, exit_d, err_d;
  logic             seq_err, commit_in, commit_out, mid;

  always_comb begin
    state_d    = state_q;
    seq_err    = 1'b0;
    commit_in  = 1'b0;
    commit_out = 1'b0;
    case (state_q)
      IDLE: case (filt_q)
              2'b10: state_d = IN1;
              2'b01: state_d = OUT1;
              2'b11: begin state_d = ERRW; seq_err = 1'b1; end
              default: ;
            endcase
      IN1:  case (filt_q)
              2'b11: state_d = IN2;
              2'b00: state_d = IDLE;
              2'b01: begin state_d = ERRW; seq_err = 1'b1; end
              default: ;
            endcase
      IN2:  case (filt_q)
              2'b01: state_d = IN3;
              2'b10: state_d = IN1;
              2'b00: begin state_d = ERRW; seq_err = 1'b1; end
              default: ;
            endcase
      IN3:  case (filt_q)
              2'b00: begin state_d = IDLE; commit_in = 1'b1; end
              2'b11: state_d = IN2;
              2'b10: begin state_d = ERRW; seq_err = 1'b1; end
              default: ;
            endcase
      OUT1: case (filt_q)
              2'b11: state_d = OUT2;
              2'b00: state_d = IDLE;
              2'b10: begin state_d = ERRW; seq_err = 1'b1; end
              default: ;
            endcase
      OUT2: case (filt_q)
              2'b10: state_d = OUT3;
              2'b01: state_d = OUT1;
              2'b00: begin state_d = ERRW; seq_err = 1'b1; end
              default: ;
            endcase
      OUT3: case (filt_q)
              2'b00: begin state_d = IDLE; commit_out = 1'b1; end
              2'b11: state_d = OUT2;
              2'b01: begin state_d = ERRW; seq_err = 1'b1; end
              default: ;
            endcase
      ERRW: if (filt_q == 2'b00) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A real transition always wins; the timeout only fires when the state would hold.
    mid = (state_q != IDLE) && (state_q != ERRW);
    if (mid && (state_d == state_q) && (tmo_q == TW'(TIMEOUT_CYCLES - 1))) begin
      state_d = ERRW;
      seq_err = 1'b1;
    end
    tmo_d = (!mid || (state_d != state_q)) ? '0 : tmo_q + 1'b1;

    occ_d   = occ_q;
    enter_d = 1'b0;
    exit_d  = 1'b0;
    err_d   = seq_err;
    if (commit_in) begin
      if (occ_q < CNT_W'(CAPACITY)) begin
        occ_d   = occ_q + 1'b1;
        enter_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    if (commit_out) begin
      if (occ_q != '0) begin
        occ_d  = occ_q - 1'b1;
        exit_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      occ_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      enter_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      occ_q   <= occ_d;
      full_q  <= (occ_d == CNT_W'(CAPACITY));
      empty_q <= (occ_d == '0);
      enter_q <= enter_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
    end
  end

  assign bus.occ_o     = occ_q;
  assign bus.full_o    = full_q;
  assign bus.empty_o   = empty_q;
  assign bus.enter_p_o = enter_q;
  assign bus.exit_p_o  = exit_q;
  assign bus.err_p_o   = err_q;
  assign bus.led_o     = {full_q, occ_q[2:0]};
endmodule

// File: doc/parking_lane_ctrl.md
# parking_lane_ctrl

Direction-decoding controller for a single bidirectional parking lane watched by two sensor pairs, A on the street side and B on the lot side. It synchronizes and debounces both raw sensor inputs and tracks the A/B pattern sequence in a state machine. On each completed entry or exit it updates a saturating occupancy counter. It drives the board LEDs with the occupancy and a full flag, and emits one-cycle event pulses for upstream logic.

## Interface
- CAPACITY, 7: maximum occupancy; must be ≤ 2^CNT_W − 1
- CNT_W, 3: occupancy counter width
- DEB_CYCLES, 4: consecutive synchronized-mismatch cycles needed to change a filtered sensor value; ≥ 1
- TIMEOUT_CYCLES, 64: maximum cycles allowed in one mid-sequence state

- CLK  in  1  system clock; all logic on rising edge
- RST_N  in  1  asynchronous, active-low reset
- SENS_A  in  1  raw sensor pair A (street side); asynchronous, may bounce
- SENS_B  in  1  raw sensor pair B (lot side)
- OCC  out  CNT_W  current occupancy
- FULL  out  1  OCC == CAPACITY
- EMPTY  out  1  OCC == 0
- ENTER_P  out  1  one-cycle pulse on each counted entry
- EXIT_P  out  1  one-cycle pulse on each counted exit
- ERR_P  out  1  one-cycle pulse on each sequence error, timeout, overflow or underflow
- LED3..LED0  out  1 each  LED3 = FULL; LED2..LED0 = OCC[2:0]

## Operation
- Input path, per sensor: 2-FF synchronizer, then a debouncer. The debouncer counter clears whenever the synchronized value equals the filtered value. The filtered value takes the synchronized value on the DEB_CYCLES-th consecutive edge at which they differ.
- The FSM operates on the filtered pair (a,b). Its states are IDLE, IN1, IN2, IN3, OUT1, OUT2, OUT3, and ERRW.
- IDLE transitions:
  - 10 → IN1
  - 01 → OUT1
  - 11 → ERRW, with ERR_P
- IN1 transitions: 11 → IN2; 00 → IDLE (back-out, no event); 01 → ERRW, with ERR_P.
- IN2 transitions: 01 → IN3; 10 → IN1; 00 → ERRW, with ERR_P.
- IN3 transitions: 00 → IDLE and commit entry; 11 → IN2; 10 → ERRW, with ERR_P.
- OUT1, OUT2 and OUT3 mirror IN1, IN2 and IN3 with a and b swapped. OUT3 → IDLE on 00 commits an exit.
- ERRW → IDLE only when the filtered pair is 00. No timeout applies in ERRW.
- Timeout: a counter clears on every state change. In IN1–IN3 or OUT1–OUT3, after TIMEOUT_CYCLES edges with no state change, the FSM goes to ERRW and pulses ERR_P.
- Entry commit:
  - OCC < CAPACITY: OCC increments and ENTER_P pulses.
  - OCC == CAPACITY: OCC is held, ERR_P pulses, and ENTER_P does not pulse.
- Exit commit:
  - OCC > 0: OCC decrements and EXIT_P pulses.
  - OCC == 0: OCC is held, ERR_P pulses, and EXIT_P does not pulse.
- At most one of ENTER_P, EXIT_P or ERR_P pulses per cycle. Any state change always takes priority over the timeout.

## Timing
- Reset values:
  - state = IDLE
  - synchronizers, filtered values and all counters = 0
  - OCC = 0, EMPTY = 1, FULL = 0
  - ENTER_P, EXIT_P, ERR_P = 0
  - LED3..LED0 = 0000
- Reset is asserted asynchronously and released synchronously to CLK. An assertion mid-sequence aborts the sequence and clears OCC.
- All outputs are registered; there are no combinational paths from input to output.
- A raw change, stable from edge 0, reaches the filtered value at edge DEB_CYCLES+2. The FSM state, OCC, FULL/EMPTY and the pulses update at edge DEB_CYCLES+3.
- Pulses are exactly one cycle wide. OCC, FULL and EMPTY change on the same edge as the corresponding pulse.
- A raw pulse shorter than DEB_CYCLES cycles, after synchronization, never changes the filtered value.

## Test plan
- Reset, then drive A,B = 10, 11, 01, 00, each held 10 cycles (DEB_CYCLES=4) → exactly one ENTER_P, 7 edges after 00 is applied; OCC 0→1; EMPTY 1→0; LED3..LED0 = 0001.
- After that entry, drive 01, 11, 10, 00 → one EXIT_P; OCC = 0; EMPTY = 1; no ERR_P.
- A high for 3 cycles, then low; separately, a back-out sequence 10, 11, 10, 00 → no state-visible event, no pulse, OCC unchanged.
- CAPACITY=3: run four entries → ENTER_P ×3, FULL = 1 and LED3 = 1 after the third; fourth entry gives ERR_P only with OCC = 3. Then run four exits → EXIT_P ×3, and the fourth exit gives ERR_P with OCC = 0.
- Error paths:
  - Hold 10 for 100 cycles → ERR_P once, TIMEOUT_CYCLES edges after IN1 is entered; state stays ERRW until 00, then returns to IDLE.
  - Drive 10 → 01 directly → ERR_P.
- Assert RST_N low mid-entry (state IN2, OCC = 2) → all outputs at reset values immediately. After release, a complete entry yields OCC = 1.
